mem_ctrl: RTL and testbench
===========================

Name: mem_ctrl

Overview:
- Single-port memory controller and arbiter between the instruction-fetch stage and the memory-access stage.
- Serializes 8-bit RAM accesses into 1/2/4-byte transfers.
- Returns an assembled instruction word to IF, or load data to MEM, and handles branch cancel of in-flight fetches.
- Sits between the pipeline stages and the external byte-wide RAM port.

Parameters:
- ADDR_W, 32, width of requester byte addresses.
- RAM_AW, 17, width of ram_addr; low RAM_AW bits of the computed address.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous active-low reset (0 = reset)
- if_req  input  1  IF fetch request (level)
- if_addr  input  ADDR_W  fetch address
- cancel  input  1  IF branch cancel; aborts or blocks a fetch
- if_mem_ctrl_done  output  1  one-cycle fetch-complete pulse
- if_rdata  output  32  fetched instruction
- mem_req  input  1  MEM access request (level)
- mem_we  input  1  1 = store, 0 = load
- mem_addr  input  ADDR_W  data byte address
- mem_width  input  2  00 byte, 01 half, 10/11 word
- mem_wdata  input  32  store data, little-endian
- mem_done  output  1  one-cycle access-complete pulse
- mem_rdata  output  32  load data, zero-extended
- busy  output  1  state != IDLE
- ram_addr  output  RAM_AW  RAM byte address
- ram_dout  output  8  RAM write byte
- ram_din  input  8  RAM read byte; valid one cycle after its address
- ram_wr  output  1  RAM write strobe

Behaviour:
- Reset (rst=0, async): state IDLE, cnt 0; all outputs 0, including if_rdata and mem_rdata.
- States: IDLE, IF_RD, MEM_RD, MEM_WR. Registered base address, byte count n (1/2/4) and 3-bit cnt.
- IDLE grant, sampled on the clock edge:
  - mem_req wins over if_req (fixed priority).
  - mem_req && mem_we goes to MEM_WR; mem_req && !mem_we goes to MEM_RD.
  - Otherwise if_req && !cancel goes to IF_RD (n=4).
  - cnt cleared to 0; address and width latched. Store data latched for MEM_WR.
- Done suppression: a requester whose done output is high in the current cycle is not granted at that edge. This prevents re-accepting a held request.
- Read states:
  - ram_addr = base+cnt while cnt<n, ram_wr=0.
  - At each edge with cnt>=1, ram_din is stored into byte cnt-1 of the result.
  - At the edge with cnt==n: capture the last byte, pulse done (if_mem_ctrl_done or mem_done) for one cycle, return to IDLE.
  - Word read: done high 5 cycles after the accept edge.
- MEM_WR:
  - ram_wr=1, ram_addr=base+cnt, ram_dout=wdata byte cnt.
  - At the edge with cnt==n-1: mem_done pulses, return to IDLE.
  - Word write: 4 RAM write cycles; done high 4 cycles after accept.
- Idle/unused outputs: ram_wr=0, ram_addr=0, ram_dout=0 outside MEM_WR/read address phases.
- rdata registers: hold their value until the next transfer for that requester begins. Unread upper bytes are 0.
- Address arithmetic: modulo 2^ADDR_W; ram_addr takes the low RAM_AW bits. No alignment check.
- Cancel during IF_RD: return to IDLE at the next edge, no done pulse, if_rdata unchanged. Cancel has no effect on MEM_* states.
- No preemption: a request arriving during a transfer waits until IDLE.
- Async reset mid-transfer: immediate IDLE. No done pulse and no further ram_wr.

Optional Feature:
- MEM_CTRL_RR_EN defined:
  - When both requests are eligible in IDLE, grant alternates; the requester not granted last wins.
  - A 1-bit last_grant register (reset 0 = IF) records the last winner.
  - A single requester is granted immediately.
- Undefined: fixed MEM-over-IF priority as above.

Test Plan:
- Fetch: if_req, if_addr=0x100, RAM[0x100..0x103]=13,05,10,00 -> ram_addr 0x100..0x103 on consecutive cycles; if_mem_ctrl_done one cycle, 5 cycles after accept; if_rdata=0x00100513; no re-grant in the done cycle.
- Store word: mem_req, mem_we=1, addr=0x2000, wdata=0xDEADBEEF -> ram_wr=1 for 4 cycles writing EF,BE,AD,DE to 0x2000..0x2003; mem_done one cycle.
- Load byte/half: width=00 at 0x2001 -> mem_rdata=0x000000BE after 2 cycles; width=01 at 0x2002 -> mem_rdata=0x0000DEAD.
- Contention: if_req and mem_req (load) in the same cycle -> MEM served first; fetch starts the cycle after mem_done. With MEM_CTRL_RR_EN, the second simultaneous pair is granted to IF.
- Cancel: assert cancel at cnt=2 of a fetch -> IDLE next edge, no done, if_rdata unchanged; new fetch to 0x200 completes normally.
- Reset: rst=0 during MEM_WR cnt=1 -> ram_wr, busy and done drop to 0 immediately; after release, an IDLE request completes normally.

Source files
------------

// File: rtl/mem_ctrl_if.sv
// Bundle of the pipeline-side request/response signals and the byte-wide RAM port of mem_ctrl.
// The controller uses the slave modport; the pipeline and RAM environment use the master modport.
interface mem_ctrl_if #(
   parameter int ADDR_W = 32,
   parameter int RAM_AW = 17
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              cancel;
   logic              if_mem_ctrl_done;
   logic [31:0]       if_rdata;

   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [1:0]        mem_width;
   logic [31:0]       mem_wdata;
   logic              mem_done;
   logic [31:0]       mem_rdata;

   logic              busy;

   logic [RAM_AW-1:0] ram_addr;
   logic [7:0]        ram_dout;
   logic [7:0]        ram_din;
   logic              ram_wr;

   modport slave (
      input  if_req, if_addr, cancel,
      input  mem_req, mem_we, mem_addr, mem_width, mem_wdata,
      input  ram_din,
      output if_mem_ctrl_done, if_rdata,
      output mem_done, mem_rdata,
      output busy,
      output ram_addr, ram_dout, ram_wr
   );

   modport master (
      output if_req, if_addr, cancel,
      output mem_req, mem_we, mem_addr, mem_width, mem_wdata,
      output ram_din,
      input  if_mem_ctrl_done, if_rdata,
      input  mem_done, mem_rdata,
      input  busy,
      input  ram_addr, ram_dout, ram_wr
   );
endinterface

// File: rtl/mem_ctrl.sv
// Single-port byte-RAM controller arbitrating instruction fetch and data access into 1/2/4-byte transfers.
// Optional macro MEM_CTRL_RR_EN: round-robin grant between IF and MEM instead of fixed MEM priority.
module mem_ctrl #(
   parameter int ADDR_W = 32,
   parameter int RAM_AW = 17
) (
   input  logic      clk,
   input  logic      rst,
   mem_ctrl_if.slave bus
);

   typedef enum logic [1:0] {IDLE, IF_RD, MEM_RD, MEM_WR} state_t;

   state_t            state, state_next;
   logic [ADDR_W-1:0] base;
   logic [2:0]        n, cnt, cnt_next, req_n;
   logic [31:0]       wdata, acc, merged;
   logic [31:0]       if_rdata_q, mem_rdata_q;
   logic              if_done_q, mem_done_q;
   logic              elig_if, elig_mem, grant_if, grant_mem, accept;
   logic              capture, fin_if, fin_mem_rd, fin_mem_wr;
   logic [1:0]        byte_idx;
   logic [RAM_AW-1:0] addr_low, ram_addr_c;
   logic [7:0]        ram_dout_c;
   logic              ram_wr_c;

`ifdef MEM_CTRL_RR_EN
   logic              last_grant;   // 0 = IF won last, 1 = MEM won last
`endif

   // A requester whose done pulse is visible this cycle is still holding its old request.
   always_comb begin
      elig_mem = bus.mem_req && !mem_done_q;
      elig_if  = bus.if_req && !bus.cancel && !if_done_q;
`ifdef MEM_CTRL_RR_EN
      grant_mem = elig_mem && (!elig_if || !last_grant);
`else
      grant_mem = elig_mem;
`endif
      grant_if = elig_if && !grant_mem;
      accept   = (state == IDLE) && (grant_mem || grant_if);
   end

   always_comb begin
      case (bus.mem_width)
         2'b00:   req_n = 3'd1;
         2'b01:   req_n = 3'd2;
         default: req_n = 3'd4;
      endcase
   end

   // Byte arriving now belongs to the address issued one cycle earlier.
   assign byte_idx = 2'(cnt - 3'd1);
   assign merged   = acc | (32'(bus.ram_din) << {byte_idx, 3'b000});
   assign addr_low = RAM_AW'(base + ADDR_W'(cnt));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_next;
   end

   // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      ram_addr_c = '0;
      ram_dout_c = '0;
      ram_wr_c   = 1'b0;
      capture    = 1'b0;
      fin_if     = 1'b0;
      fin_mem_rd = 1'b0;
      fin_mem_wr = 1'b0;
      case (state)
         IDLE: begin
            cnt_next = 3'd0;
            if (grant_mem)     state_next = bus.mem_we ? MEM_WR : MEM_RD;
            else if (grant_if) state_next = IF_RD;
         end
         IF_RD, MEM_RD: begin
            if (cnt < n) ram_addr_c = addr_low;
            if (state == IF_RD && bus.cancel) begin
               state_next = IDLE;
               cnt_next   = 3'd0;
            end else begin
               capture = (cnt != 3'd0);
               if (cnt == n) begin
                  state_next = IDLE;
                  cnt_next   = 3'd0;
                  fin_if     = (state == IF_RD);
                  fin_mem_rd = (state == MEM_RD);
               end else begin
                  cnt_next = cnt + 3'd1;
               end
            end
         end
         MEM_WR: begin
            ram_wr_c   = 1'b1;
            ram_addr_c = addr_low;
            ram_dout_c = 8'(wdata >> {cnt[1:0], 3'b000});
            if (cnt == n - 3'd1) begin
               state_next = IDLE;
               cnt_next   = 3'd0;
               fin_mem_wr = 1'b1;
            end else begin
               cnt_next = cnt + 3'd1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt         <= 3'd0;
         n           <= 3'd0;
         base        <= '0;
         wdata       <= '0;
         acc         <= '0;
         if_done_q   <= 1'b0;
         mem_done_q  <= 1'b0;
         if_rdata_q  <= '0;
         mem_rdata_q <= '0;
      end else begin
         cnt        <= cnt_next;
         if_done_q  <= fin_if;
         mem_done_q <= fin_mem_rd || fin_mem_wr;
         if (accept) begin
            base <= grant_mem ? bus.mem_addr : bus.if_addr;
            n    <= grant_mem ? req_n : 3'd4;
            acc  <= '0;
            if (grant_mem && bus.mem_we) wdata <= bus.mem_wdata;
         end
         if (capture)    acc         <= merged;
         if (fin_if)     if_rdata_q  <= merged;
         if (fin_mem_rd) mem_rdata_q <= merged;
      end
   end

`ifdef MEM_CTRL_RR_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)        last_grant <= 1'b0;
      else if (accept) last_grant <= grant_mem;
   end
`endif

   assign bus.if_mem_ctrl_done = if_done_q;
   assign bus.if_rdata         = if_rdata_q;
   assign bus.mem_done         = mem_done_q;
   assign bus.mem_rdata        = mem_rdata_q;
   assign bus.busy             = (state != IDLE);
   assign bus.ram_addr         = ram_addr_c;
   assign bus.ram_dout         = ram_dout_c;
   assign bus.ram_wr           = ram_wr_c;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed self-checking bench for mem_ctrl with a byte-wide RAM model (one-cycle read latency).
// Builds with or without MEM_CTRL_RR_EN; only the contention order depends on it.
module tb_mem_ctrl;
   localparam int ADDR_W = 32;
   localparam int RAM_AW = 17;
`ifdef MEM_CTRL_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_err = 0;
   bit   first_if;
   logic [7:0] ram [0:(1<<RAM_AW)-1];

   mem_ctrl_if #(.ADDR_W(ADDR_W), .RAM_AW(RAM_AW)) bus ();

   mem_ctrl #(.ADDR_W(ADDR_W), .RAM_AW(RAM_AW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bus.ram_wr) ram[bus.ram_addr] <= bus.ram_dout;
      bus.ram_din <= ram[bus.ram_addr];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic req_read(input bit is_if, input logic [31:0] addr, input logic [1:0] width);
      if (is_if) begin
         bus.if_req  = 1'b1;
         bus.if_addr = addr;
      end else begin
         bus.mem_req   = 1'b1;
         bus.mem_we    = 1'b0;
         bus.mem_addr  = addr;
         bus.mem_width = width;
      end
   endtask

   task automatic drop(input bit is_if);
      if (is_if) bus.if_req  = 1'b0;
      else       bus.mem_req = 1'b0;
   endtask

   // Checks the address phase, the data-return cycle and the done pulse of one granted read.
   task automatic expect_read(input bit is_if, input logic [31:0] addr, input int nb,
                              input logic [31:0] exp, input string tag);
      for (int k = 0; k < nb; k++) begin
         @(negedge clk);
         check($sformatf("%s busy%0d", tag, k), 32'(bus.busy), 32'd1);
         check($sformatf("%s ram_addr%0d", tag, k), 32'(bus.ram_addr),
               32'(RAM_AW'(addr + 32'(k))));
      end
      @(negedge clk);
      check({tag, " early_done"}, {30'd0, bus.if_mem_ctrl_done, bus.mem_done}, 32'd0);
      check({tag, " tail_addr"}, 32'(bus.ram_addr), 32'd0);
      @(negedge clk);
      check({tag, " if_done"}, 32'(bus.if_mem_ctrl_done), 32'(is_if));
      check({tag, " mem_done"}, 32'(bus.mem_done), 32'(!is_if));
      check({tag, " rdata"}, is_if ? bus.if_rdata : bus.mem_rdata, exp);
   endtask

   task automatic expect_write(input logic [31:0] addr, input int nb, input logic [31:0] data,
                               input string tag);
      for (int k = 0; k < nb; k++) begin
         @(negedge clk);
         check($sformatf("%s ram_wr%0d", tag, k), 32'(bus.ram_wr), 32'd1);
         check($sformatf("%s ram_addr%0d", tag, k), 32'(bus.ram_addr),
               32'(RAM_AW'(addr + 32'(k))));
         check($sformatf("%s ram_dout%0d", tag, k), 32'(bus.ram_dout), 32'(8'(data >> (8*k))));
         check($sformatf("%s early_done%0d", tag, k), 32'(bus.mem_done), 32'd0);
      end
      @(negedge clk);
      check({tag, " mem_done"}, 32'(bus.mem_done), 32'd1);
      check({tag, " wr_off"}, 32'(bus.ram_wr), 32'd0);
   endtask

   // One cycle after a done pulse with the request still held: no re-grant, no pulse.
   task automatic idle_check(input string tag);
      @(negedge clk);
      check({tag, " busy"}, 32'(bus.busy), 32'd0);
      check({tag, " dones"}, {30'd0, bus.if_mem_ctrl_done, bus.mem_done}, 32'd0);
      check({tag, " ram_wr"}, 32'(bus.ram_wr), 32'd0);
   endtask

   initial begin
      rst           = 1'b0;
      bus.if_req    = 1'b0;
      bus.if_addr   = '0;
      bus.cancel    = 1'b0;
      bus.mem_req   = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_width = 2'b00;
      bus.mem_wdata = '0;
      first_if      = RR;

      {ram[32'h103], ram[32'h102], ram[32'h101], ram[32'h100]} = 32'h00100513;
      {ram[32'h203], ram[32'h202], ram[32'h201], ram[32'h200]} = 32'h00100093;
      {ram[32'h303], ram[32'h302], ram[32'h301], ram[32'h300]} = 32'hCAFEBABE;
      {ram[32'h2003], ram[32'h2002], ram[32'h2001], ram[32'h2000]} = 32'h0;
      {ram[32'h3003], ram[32'h3002], ram[32'h3001], ram[32'h3000]} = 32'h0;
      {ram[32'h1], ram[32'h0], ram[32'h1FFFF], ram[32'h1FFFE]} = 32'h44332211;

      @(negedge clk);
      check("rst busy", 32'(bus.busy), 32'd0);
      check("rst ram_wr", 32'(bus.ram_wr), 32'd0);
      check("rst ram_addr", 32'(bus.ram_addr), 32'd0);
      check("rst ram_dout", 32'(bus.ram_dout), 32'd0);
      check("rst dones", {30'd0, bus.if_mem_ctrl_done, bus.mem_done}, 32'd0);
      check("rst if_rdata", bus.if_rdata, 32'd0);
      check("rst mem_rdata", bus.mem_rdata, 32'd0);
      @(negedge clk);
      rst = 1'b1;

      // Fetch with the request held through the done cycle.
      req_read(1'b1, 32'h100, 2'b10);
      expect_read(1'b1, 32'h100, 4, 32'h00100513, "fetch");
      idle_check("fetch_hold");
      drop(1'b1);

      // Store word, little-endian byte order.
      bus.mem_req   = 1'b1;
      bus.mem_we    = 1'b1;
      bus.mem_addr  = 32'h2000;
      bus.mem_width = 2'b10;
      bus.mem_wdata = 32'hDEADBEEF;
      expect_write(32'h2000, 4, 32'hDEADBEEF, "stw");
      idle_check("stw_hold");
      bus.mem_req = 1'b0;
      bus.mem_we  = 1'b0;

      // Byte and half loads read back the stored word.
      req_read(1'b0, 32'h2001, 2'b00);
      expect_read(1'b0, 32'h2001, 1, 32'h000000BE, "ldb");
      idle_check("ldb_hold");
      drop(1'b0);
      @(negedge clk);
      check("ldb keep", bus.mem_rdata, 32'h000000BE);

      req_read(1'b0, 32'h2002, 2'b01);
      expect_read(1'b0, 32'h2002, 2, 32'h0000DEAD, "ldh");
      idle_check("ldh_hold");
      drop(1'b0);

      // Simultaneous requests: fixed priority gives MEM first; round-robin gives IF first
      // because the previous winner was MEM.
      req_read(1'b1, 32'h100, 2'b10);
      req_read(1'b0, 32'h2000, 2'b10);
      expect_read(first_if, first_if ? 32'h100 : 32'h2000, 4,
                  first_if ? 32'h00100513 : 32'hDEADBEEF, "cont_first");
      drop(first_if);
      expect_read(!first_if, first_if ? 32'h2000 : 32'h100, 4,
                  first_if ? 32'hDEADBEEF : 32'h00100513, "cont_second");
      idle_check("cont_hold");
      drop(!first_if);

      // Cancel at cnt=2 of a fetch: aborted without done, old instruction kept.
      req_read(1'b1, 32'h300, 2'b10);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check($sformatf("cancel ram_addr%0d", k), 32'(bus.ram_addr), 32'h300 + 32'(k));
      end
      bus.cancel = 1'b1;
      bus.if_req = 1'b0;
      @(negedge clk);
      check("cancel busy", 32'(bus.busy), 32'd0);
      check("cancel no_done", 32'(bus.if_mem_ctrl_done), 32'd0);
      check("cancel rdata", bus.if_rdata, 32'h00100513);
      @(negedge clk);
      check("cancel no_done2", 32'(bus.if_mem_ctrl_done), 32'd0);
      bus.cancel = 1'b0;

      req_read(1'b1, 32'h200, 2'b10);
      expect_read(1'b1, 32'h200, 4, 32'h00100093, "refetch");
      idle_check("refetch_hold");
      drop(1'b1);

      // ram_addr keeps only the low RAM_AW bits; the 32-bit address wraps.
      req_read(1'b1, 32'h0001FFFE, 2'b10);
      expect_read(1'b1, 32'h0001FFFE, 4, 32'h44332211, "wrap_fetch");
      idle_check("wrap_fetch_hold");
      drop(1'b1);

      req_read(1'b0, 32'hFFFFFFFF, 2'b01);
      expect_read(1'b0, 32'hFFFFFFFF, 2, 32'h00003322, "wrap_ldh");
      idle_check("wrap_ldh_hold");
      drop(1'b0);

      // Reset during the second write byte: everything drops at once, only one byte lands.
      bus.mem_req   = 1'b1;
      bus.mem_we    = 1'b1;
      bus.mem_addr  = 32'h3000;
      bus.mem_width = 2'b10;
      bus.mem_wdata = 32'h11223344;
      @(negedge clk);
      check("rstwr dout0", 32'(bus.ram_dout), 32'h44);
      @(negedge clk);
      check("rstwr ram_wr1", 32'(bus.ram_wr), 32'd1);
      check("rstwr addr1", 32'(bus.ram_addr), 32'h3001);
      #2 rst = 1'b0;
      #1;
      check("rstwr ram_wr", 32'(bus.ram_wr), 32'd0);
      check("rstwr busy", 32'(bus.busy), 32'd0);
      check("rstwr done", 32'(bus.mem_done), 32'd0);
      check("rstwr ram_addr", 32'(bus.ram_addr), 32'd0);
      check("rstwr mem_rdata", bus.mem_rdata, 32'd0);
      check("rstwr if_rdata", bus.if_rdata, 32'd0);
      bus.mem_req = 1'b0;
      bus.mem_we  = 1'b0;
      @(negedge clk);
      rst = 1'b1;

      req_read(1'b0, 32'h3000, 2'b10);
      expect_read(1'b0, 32'h3000, 4, 32'h00000044, "post_rst");
      idle_check("post_rst_hold");
      drop(1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
